// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches one word per request from
// instruction memory and hands it to decode. When decode retires the word, the
// next PC is chosen from the jr / jump / branch / sequential controls.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        beq,
    input  logic        bne,
    input  logic        jump,
    input  logic        jr,
    input  logic        alu_zero,
    input  logic [31:0] rs_data,
    output logic        misalign
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        misalign_q, misalign_d;
    logic        retire;
    logic        br_taken;
    logic [31:0] seq_pc;

    // Sign-extended word offset added to pc+4; wraps modulo 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                  input logic [15:0] imm);
        logic signed [31:0] offset;
        offset = {{14{imm[15]}}, imm, 2'b00};
        return base + $unsigned(offset);
    endfunction

    assign seq_pc   = pc_q + 32'd4;
    assign retire   = (state_q == S_VALID) && instr_ready;
    assign br_taken = (beq && alu_zero) || (bne && !alu_zero);

    // State register; an ack in the reset cycle is lost with the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> FETCH -> (ack) VALID -> (ready) FETCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (imem_ack) state_d = S_VALID;
            S_VALID: if (instr_ready) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state only, so no input-to-output path.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            S_FETCH: imem_req    = 1'b1;
            S_VALID: instr_valid = 1'b1;
            default: ;
        endcase
    end

    // Next PC / captured word / misalign pulse; controls matter only on retire.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = 1'b0;
        if (state_q == S_FETCH && imem_ack) begin
            instr_d = imem_rdata;
        end
        if (retire) begin
            if (jr) begin
                pc_d       = {rs_data[31:2], 2'b00};
                misalign_d = |rs_data[1:0];
            end else if (jump) begin
                pc_d = {seq_pc[31:28], instr_q[25:0], 2'b00};
            end else if (br_taken) begin
                pc_d = branch_target(seq_pc, instr_q[15:0]);
            end else begin
                pc_d = seq_pc;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign pc_plus4  = seq_pc;
    assign instr     = instr_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a memory responder and a decode driver, with
// expected fetch addresses and presented words queued as stimulus is issued.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        beq, bne, jump, jr, alu_zero;
    logic [31:0] rs_data;
    logic        misalign;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_pc_q[$];

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc(pc), .pc_plus4(pc_plus4),
        .beq(beq), .bne(bne), .jump(jump), .jr(jr), .alu_zero(alu_zero),
        .rs_data(rs_data), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        beq = 0; bne = 0; jump = 0; jr = 0; alu_zero = 0; rs_data = '0;
    endtask

    // Wait for a request, check its address, hold off 'delay' cycles, then ack.
    task automatic serve(input logic [31:0] word, input int delay,
                         output int waited);
        logic [31:0] ea;
        waited = 0;
        while (!imem_req && waited < 20) begin
            step();
            waited++;
        end
        if (!imem_req) begin
            check("req_timeout", 32'(imem_req), 32'd1);
            return;
        end
        ea = exp_addr_q.pop_front();
        check("fetch_addr", imem_addr, ea);
        check("valid_in_fetch", 32'(instr_valid), 32'd0);
        for (int i = 0; i < delay; i++) begin
            step();
            check("req_held", 32'(imem_req), 32'd1);
            check("addr_held", imem_addr, ea);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        exp_instr_q.push_back(word);
        exp_pc_q.push_back(ea);
    endtask

    // Check the presented word, then hold it 'hold' cycles with noise on inputs.
    task automatic present(input int hold);
        logic [31:0] ei, ep;
        int w = 0;
        while (!instr_valid && w < 20) begin
            step();
            w++;
        end
        check("valid_latency", 32'(w), 32'd0);
        ei = exp_instr_q.pop_front();
        ep = exp_pc_q.pop_front();
        check("instr", instr, ei);
        check("pc", pc, ep);
        check("pc_plus4", pc_plus4, ep + 32'd4);
        check("misalign_idle", 32'(misalign), 32'd0);
        for (int i = 0; i < hold; i++) begin
            beq = $urandom; bne = $urandom; jump = $urandom; jr = 1'b1;
            alu_zero = $urandom; rs_data = 32'h0000_0033 ^ $urandom;
            imem_ack = 1'b1; imem_rdata = $urandom;
            step();
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_req", 32'(imem_req), 32'd0);
            check("hold_instr", instr, ei);
            check("hold_pc", pc, ep);
            check("hold_misalign", 32'(misalign), 32'd0);
        end
        imem_ack = 1'b0;
        clear_ctrl();
    endtask

    // Retire with the given controls; queue the next fetch address.
    task automatic retire(input logic b_eq, input logic b_ne, input logic jmp,
                          input logic j_r, input logic az,
                          input logic [31:0] rs, input logic [31:0] next_pc,
                          input logic exp_mis);
        beq = b_eq; bne = b_ne; jump = jmp; jr = j_r; alu_zero = az;
        rs_data = rs;
        instr_ready = 1'b1;
        exp_addr_q.push_back(next_pc);
        step();
        instr_ready = 1'b0;
        clear_ctrl();
        check("misalign", 32'(misalign), 32'(exp_mis));
    endtask

    initial begin
        int wt;
        reset = 1; imem_ack = 0; imem_rdata = '0; instr_ready = 0;
        clear_ctrl();
        repeat (3) step();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc, RST_PC);
        check("rst_misalign", 32'(misalign), 32'd0);
        exp_addr_q.push_back(RST_PC);
        reset = 0;

        // Sequential stream from reset, zero-wait memory.
        serve(32'h2008_0001, 0, wt); check("first_req_wait", 32'(wt), 32'd1);
        present(0); retire(0, 0, 0, 0, 0, 0, 32'h0040_0004, 0);
        serve(32'h2008_0002, 0, wt); check("seq_wait", 32'(wt), 32'd0);
        present(0); retire(0, 0, 0, 0, 0, 0, 32'h0040_0008, 0);
        serve(32'h2008_0003, 0, wt); check("seq_wait", 32'(wt), 32'd0);
        present(0); retire(0, 0, 0, 1, 0, 32'h0000_0100, 32'h0000_0100, 0);

        // Branches at 0x100 with offset -2 words.
        serve(32'h1000_FFFE, 0, wt); present(0);
        retire(1, 0, 0, 0, 1, 0, 32'h0000_00FC, 0);
        serve(32'h0, 0, wt); present(0);
        retire(0, 0, 0, 1, 0, 32'h0000_0100, 32'h0000_0100, 0);
        serve(32'h1000_FFFE, 0, wt); present(0);
        retire(1, 0, 0, 0, 0, 0, 32'h0000_0104, 0);
        serve(32'h0, 0, wt); present(0);
        retire(0, 0, 0, 1, 0, 32'h0000_0100, 32'h0000_0100, 0);
        serve(32'h1400_FFFE, 0, wt); present(0);
        retire(0, 1, 0, 0, 1, 0, 32'h0000_0104, 0);
        serve(32'h0, 0, wt); present(0);
        retire(0, 0, 0, 1, 0, 32'h0000_0100, 32'h0000_0100, 0);
        serve(32'h1400_FFFE, 0, wt); present(0);
        retire(0, 1, 0, 0, 0, 0, 32'h0000_00FC, 0);
        serve(32'h0, 0, wt); present(0);
        retire(0, 0, 0, 1, 0, 32'h1000_0000, 32'h1000_0000, 0);

        // Jump, misaligned jr, then jr+jump priority under stalls.
        serve(32'h0800_0040, 0, wt); present(0);
        retire(0, 0, 1, 0, 0, 0, 32'h1000_0100, 0);
        serve(32'h0, 0, wt); present(0);
        retire(0, 0, 0, 1, 0, 32'h0000_0203, 32'h0000_0200, 1);
        serve(32'h0800_0FFF, 3, wt); present(4);
        retire(1, 0, 1, 1, 1, 32'h0000_0300, 32'h0000_0300, 0);
        serve(32'h0, 0, wt); present(0);
        retire(0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0);

        // Wrap at the top of the address space.
        serve(32'h0, 0, wt); present(0);
        retire(0, 0, 0, 0, 0, 0, 32'h0000_0000, 0);

        // Reset in FETCH with a simultaneous ack.
        check("pre_rst_req", 32'(imem_req), 32'd1);
        check("pre_rst_addr", imem_addr, exp_addr_q.pop_front());
        reset = 1; imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        step();
        reset = 0; imem_ack = 0;
        check("rst_fetch_valid", 32'(instr_valid), 32'd0);
        check("rst_fetch_req", 32'(imem_req), 32'd0);
        check("rst_fetch_instr", instr, 32'h0);
        check("rst_fetch_pc", pc, RST_PC);
        exp_addr_q.push_back(RST_PC);
        serve(32'h2008_0009, 0, wt); check("restart_wait", 32'(wt), 32'd1);
        present(0); retire(0, 0, 0, 0, 0, 0, 32'h0040_0004, 0);
        serve(32'h2008_000A, 0, wt); present(0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
